vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
Produces the 10-bit horizontal and vertical pixel counters that drive the segment-mask decoder, plus hsync/vsync, an active-video flag and a frame-start strobe.
Horizontal count 0 is the start of the hsync pulse, so visible pixels begin at count H_SYNC+H_BP = 144. The downstream decoder's Hbias depends on this.
Sits between the clock input and the digit mask decoder / RGB output stage.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/pixel_tick_gen.sv | 31 +++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Standard 640x480@60 Hz VGA timing constants and small shared helpers.
// Horizontal/vertical count 0 is the start of the sync pulse.
package vga_timing_pkg;

    typedef logic [9:0] cnt_t;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_ACTIVE = 480;

    // Visible windows, start inclusive, end exclusive (144..783 and 35..514).
    localparam int H_VIS_START = VGA_H_SYNC + VGA_H_BP;
    localparam int H_VIS_END   = H_VIS_START + VGA_H_ACTIVE;
    localparam int V_VIS_START = VGA_V_SYNC + VGA_V_BP;
    localparam int V_VIS_END   = V_VIS_START + VGA_V_ACTIVE;

    function automatic cnt_t wrap_inc(input cnt_t c, input cnt_t last);
        return (c == last) ? '0 : c + 10'd1;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock by CLK_DIV and emits a registered one-clock
// pixel enable; with CLK_DIV=1 the enable stays high after the first edge.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= (div == DIV_LAST);
            div      <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
        end
    end

    generate
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("pixel_tick_gen: CLK_DIV must be in 1..16");
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, active-video
// and frame-start outputs, all aligned with the counter values they describe.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick,
    output logic [9:0] horiz_Cnt,
    output logic [9:0] vert_Cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam cnt_t        H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t        V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
    localparam logic [10:0] H_VIS_LO = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_VIS_HI = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_VIS_LO = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_VIS_HI = 11'(V_SYNC + V_BP + V_ACTIVE);

    // Compared at 11 bits so a window ending exactly at 1024 still works.
    function automatic logic past_sync(input cnt_t c, input logic [10:0] width);
        return {1'b0, c} >= width;
    endfunction

    function automatic logic in_window(input cnt_t c, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return ({1'b0, c} >= lo) && ({1'b0, c} < hi);
    endfunction

    cnt_t h_next;
    cnt_t v_next;
    logic h_wrap;
    logic v_wrap;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );

    always_comb begin
        h_wrap = pix_tick && (horiz_Cnt == H_LAST);
        v_wrap = h_wrap && (vert_Cnt == V_LAST);
        h_next = pix_tick ? wrap_inc(horiz_Cnt, H_LAST) : horiz_Cnt;
        v_next = h_wrap ? wrap_inc(vert_Cnt, V_LAST) : vert_Cnt;
    end

    // Decode from next-state counts so outputs line up with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            horiz_Cnt   <= '0;
            vert_Cnt    <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            horiz_Cnt   <= h_next;
            vert_Cnt    <= v_next;
            hsync       <= past_sync(h_next, H_SYNC_W);
            vsync       <= past_sync(v_next, V_SYNC_W);
            video_on    <= in_window(h_next, H_VIS_LO, H_VIS_HI) &&
                           in_window(v_next, V_VIS_LO, V_VIS_HI);
            frame_start <= v_wrap;
        end
    end

    generate
        if (H_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL < 1 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must be in 1..1024");
        end
        if (H_SYNC + H_BP + H_ACTIVE > H_TOTAL) begin : g_bad_h
            $error("vga_timing_gen: horizontal sync+porch+active exceeds H_TOTAL");
        end
        if (V_SYNC + V_BP + V_ACTIVE > V_TOTAL) begin : g_bad_v
            $error("vga_timing_gen: vertical sync+porch+active exceeds V_TOTAL");
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default, CLK_DIV=1, shrunken frame)
// checked against a closed-form model driven by clocks since reset release.
module tb_vga_timing_gen;

    localparam int C_D  = 3;
    localparam int C_HT = 40, C_HS = 4, C_HB = 6, C_HA = 24;
    localparam int C_VT = 30, C_VS = 2, C_VB = 3, C_VA = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;

    logic       a_tick, a_hs, a_vs, a_vid, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_tick, b_hs, b_vs, b_vid, b_fs;
    logic [9:0] b_h, b_v;
    logic       c_tick, c_hs, c_vs, c_vid, c_fs;
    logic [9:0] c_h, c_v;

    int n_cmp = 0;
    int n_bad = 0;

    vga_timing_gen dut_a (
        .clk (clk), .rst_n (rst_a), .pix_tick (a_tick), .horiz_Cnt (a_h),
        .vert_Cnt (a_v), .hsync (a_hs), .vsync (a_vs), .video_on (a_vid),
        .frame_start (a_fs)
    );

    vga_timing_gen #(.CLK_DIV(1)) dut_b (
        .clk (clk), .rst_n (rst_b), .pix_tick (b_tick), .horiz_Cnt (b_h),
        .vert_Cnt (b_v), .hsync (b_hs), .vsync (b_vs), .video_on (b_vid),
        .frame_start (b_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(C_D), .H_TOTAL(C_HT), .H_SYNC(C_HS), .H_BP(C_HB), .H_ACTIVE(C_HA),
        .V_TOTAL(C_VT), .V_SYNC(C_VS), .V_BP(C_VB), .V_ACTIVE(C_VA)
    ) dut_c (
        .clk (clk), .rst_n (rst_c), .pix_tick (c_tick), .horiz_Cnt (c_h),
        .vert_Cnt (c_v), .hsync (c_hs), .vsync (c_vs), .video_on (c_vid),
        .frame_start (c_fs)
    );

    // Clock edges seen since each DUT's reset was released.
    int ka, kb, kc;
    always @(posedge clk or negedge rst_a) if (!rst_a) ka <= 0; else ka <= ka + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) kb <= 0; else kb <= kb + 1;
    always @(posedge clk or negedge rst_c) if (!rst_c) kc <= 0; else kc <= kc + 1;

    // {tick, h, v, hsync, vsync, video_on, frame_start}
    function automatic logic [24:0] model(input int k, input int d,
                                          input int ht, input int hs, input int hb, input int ha,
                                          input int vt, input int vs, input int vb, input int va);
        int   p, h, v;
        logic t, f, hso, vso, vid;
        p   = (k == 0) ? 0 : (k - 1) / d;
        t   = (k >= d) && (k % d == 0);
        h   = p % ht;
        v   = (p / ht) % vt;
        f   = (k - 1 >= d) && ((k - 1) % d == 0) && (p % (ht * vt) == 0);
        hso = (h >= hs);
        vso = (v >= vs);
        vid = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
        return {t, h[9:0], v[9:0], hso, vso, vid, f};
    endfunction

    function automatic logic [24:0] obs_pack(input logic t, input logic [9:0] h, input logic [9:0] v,
                                             input logic hs, input logic vs, input logic vid,
                                             input logic fs);
        return {t, h, v, hs, vs, vid, fs};
    endfunction

    function automatic logic [24:0] obs_a();
        return obs_pack(a_tick, a_h, a_v, a_hs, a_vs, a_vid, a_fs);
    endfunction
    function automatic logic [24:0] obs_b();
        return obs_pack(b_tick, b_h, b_v, b_hs, b_vs, b_vid, b_fs);
    endfunction
    function automatic logic [24:0] obs_c();
        return obs_pack(c_tick, c_h, c_v, c_hs, c_vs, c_vid, c_fs);
    endfunction

    task automatic reset_a();
        rst_a = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_a = 1'b1;
    endtask
    task automatic reset_b();
        rst_b = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_b = 1'b1;
    endtask
    task automatic reset_c();
        rst_c = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_c = 1'b1;
    endtask

    task automatic test_reset();
        logic [24:0] exp;
        rst_a = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs_a() !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_state got %h want %h", obs_a(), 25'd0);
        end
        rst_a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i <= 3)      exp = 25'd0;
            else if (i == 4) exp = obs_pack(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            else             exp = obs_pack(1'b0, 10'd1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs_a() !== exp) begin
                n_bad++;
                $display("FAIL reset_release clk=%0d got %h want %h", i, obs_a(), exp);
            end
        end
    endtask

    task automatic test_line();
        logic [24:0] exp;
        int bad = 0, k0 = -1, k1 = -1, hs_low = 0;
        logic [9:0] prev_h = '0;
        reset_a();
        for (int i = 0; i < 3210; i++) begin
            @(negedge clk);
            exp = model(ka, 4, 800, 96, 48, 640, 525, 2, 33, 480);
            n_cmp++;
            if (obs_a() !== exp) begin
                n_bad++; bad++;
                $display("FAIL line_model k=%0d got %h want %h", ka, obs_a(), exp);
                if (bad >= 10) break;
            end
            if (a_h == 10'd0 && prev_h == 10'd799) begin
                n_cmp++;
                if (a_v !== 10'd1) begin
                    n_bad++;
                    $display("FAIL line_wrap_vert got %0d want 1", a_v);
                end
            end
            if (a_h == 10'd1 && a_v == 10'd0 && k0 < 0) k0 = ka;
            if (a_h == 10'd1 && a_v == 10'd1 && k1 < 0) k1 = ka;
            if (k0 >= 0 && k1 < 0 && !a_hs) hs_low++;
            prev_h = a_h;
        end
        n_cmp++;
        if (k1 - k0 !== 3200 || k0 < 0 || k1 < 0) begin
            n_bad++;
            $display("FAIL line_span got %0d clks want 3200", k1 - k0);
        end
        n_cmp++;
        if (hs_low !== 384) begin
            n_bad++;
            $display("FAIL hsync_width got %0d clks want 384", hs_low);
        end
    endtask

    task automatic test_mid_reset();
        logic [24:0] exp;
        int bad = 0;
        reset_a();
        repeat ($urandom_range(2000, 6000)) @(negedge clk);
        @(posedge clk);
        #3;
        rst_a = 1'b0;
        #1;
        n_cmp++;
        if (obs_a() !== 25'd0) begin
            n_bad++;
            $display("FAIL async_clear got %h want %h", obs_a(), 25'd0);
        end
        @(negedge clk);
        rst_a = 1'b1;
        for (int i = 0; i < 3300; i++) begin
            @(negedge clk);
            exp = model(ka, 4, 800, 96, 48, 640, 525, 2, 33, 480);
            n_cmp++;
            if (obs_a() !== exp) begin
                n_bad++; bad++;
                $display("FAIL mid_reset_model k=%0d got %h want %h", ka, obs_a(), exp);
                if (bad >= 10) break;
            end
        end
    endtask

    task automatic test_frame();
        logic [24:0] exp;
        int bad = 0, f1 = -1, f2 = -1, n_fs = 0, vs_low = 0, max_h = 0, max_v = 0;
        int wh[6]   = '{9, 10, 33, 34, 10, 10};
        int wv[6]   = '{5, 5, 24, 24, 4, 25};
        logic wvid[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int hit[6]  = '{0, 0, 0, 0, 0, 0};
        reset_c();
        for (int i = 0; i < 7215; i++) begin
            @(negedge clk);
            exp = model(kc, C_D, C_HT, C_HS, C_HB, C_HA, C_VT, C_VS, C_VB, C_VA);
            n_cmp++;
            if (obs_c() !== exp) begin
                n_bad++; bad++;
                $display("FAIL frame_model k=%0d got %h want %h", kc, obs_c(), exp);
                if (bad >= 10) break;
            end
            for (int j = 0; j < 6; j++) begin
                if (int'(c_h) == wh[j] && int'(c_v) == wv[j]) begin
                    hit[j]++;
                    n_cmp++;
                    if (c_vid !== wvid[j]) begin
                        n_bad++;
                        $display("FAIL window_edge (%0d,%0d) got %b want %b", c_h, c_v, c_vid, wvid[j]);
                    end
                end
            end
            if (c_fs) begin
                n_fs++;
                if (f1 < 0) f1 = kc; else if (f2 < 0) f2 = kc;
            end
            if (f1 >= 0 && f2 < 0 && !c_vs) vs_low++;
            if (int'(c_h) > max_h) max_h = int'(c_h);
            if (int'(c_v) > max_v) max_v = int'(c_v);
        end
        n_cmp++;
        if (n_fs !== 2) begin
            n_bad++;
            $display("FAIL frame_start_count got %0d want 2", n_fs);
        end
        n_cmp++;
        if (f2 - f1 !== C_HT * C_VT * C_D || f1 < 0 || f2 < 0) begin
            n_bad++;
            $display("FAIL frame_period got %0d want %0d", f2 - f1, C_HT * C_VT * C_D);
        end
        n_cmp++;
        if (vs_low !== C_VS * C_HT * C_D) begin
            n_bad++;
            $display("FAIL vsync_width got %0d want %0d", vs_low, C_VS * C_HT * C_D);
        end
        n_cmp++;
        if (max_h > C_HT - 1 || max_v > C_VT - 1) begin
            n_bad++;
            $display("FAIL count_range got %0d/%0d want <= %0d/%0d", max_h, max_v, C_HT - 1, C_VT - 1);
        end
        for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if (hit[j] == 0) begin
                n_bad++;
                $display("FAIL window_reached (%0d,%0d) got 0 visits want >0", wh[j], wv[j]);
            end
        end
    endtask

    task automatic test_clkdiv1();
        logic [24:0] exp;
        int bad = 0, k0 = -1, k1 = -1, hs_low = 0;
        logic [9:0] prev_h = '0;
        reset_b();
        for (int i = 0; i < 810; i++) begin
            @(negedge clk);
            exp = model(kb, 1, 800, 96, 48, 640, 525, 2, 33, 480);
            n_cmp++;
            if (obs_b() !== exp) begin
                n_bad++; bad++;
                $display("FAIL div1_model k=%0d got %h want %h", kb, obs_b(), exp);
                if (bad >= 10) break;
            end
            if (kb >= 1) begin
                n_cmp++;
                if (b_tick !== 1'b1) begin
                    n_bad++;
                    $display("FAIL div1_tick k=%0d got %b want 1", kb, b_tick);
                end
            end
            if (kb >= 2) begin
                n_cmp++;
                if (b_h !== ((prev_h == 10'd799) ? 10'd0 : prev_h + 10'd1)) begin
                    n_bad++;
                    $display("FAIL div1_step k=%0d got %0d after %0d", kb, b_h, prev_h);
                end
            end
            if (b_h == 10'd1 && b_v == 10'd0 && k0 < 0) k0 = kb;
            if (b_h == 10'd1 && b_v == 10'd1 && k1 < 0) k1 = kb;
            if (k0 >= 0 && k1 < 0 && !b_hs) hs_low++;
            prev_h = b_h;
        end
        n_cmp++;
        if (k1 - k0 !== 800 || k0 < 0 || k1 < 0) begin
            n_bad++;
            $display("FAIL div1_line_span got %0d clks want 800", k1 - k0);
        end
        n_cmp++;
        if (hs_low !== 96) begin
            n_bad++;
            $display("FAIL div1_hsync_width got %0d want 96", hs_low);
        end
    endtask

    task automatic test_window();
        logic [24:0] exp;
        int bad = 0;
        int wh[3]   = '{143, 144, 144};
        int wv[3]   = '{35, 35, 34};
        logic wvid[3] = '{1'b0, 1'b1, 1'b0};
        int hit[3]  = '{0, 0, 0};
        reset_b();
        for (int i = 0; i < 28150; i++) begin
            @(negedge clk);
            exp = model(kb, 1, 800, 96, 48, 640, 525, 2, 33, 480);
            n_cmp++;
            if (obs_b() !== exp) begin
                n_bad++; bad++;
                $display("FAIL window_model k=%0d got %h want %h", kb, obs_b(), exp);
                if (bad >= 10) break;
            end
            for (int j = 0; j < 3; j++) begin
                if (int'(b_h) == wh[j] && int'(b_v) == wv[j]) begin
                    hit[j]++;
                    n_cmp++;
                    if (b_vid !== wvid[j]) begin
                        n_bad++;
                        $display("FAIL video_on (%0d,%0d) got %b want %b", b_h, b_v, b_vid, wvid[j]);
                    end
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (hit[j] == 0) begin
                n_bad++;
                $display("FAIL video_on_reached (%0d,%0d) got 0 visits want >0", wh[j], wv[j]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_line();
        test_mid_reset();
        test_frame();
        test_clkdiv1();
        test_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
